// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches words over a req/ready
// handshake and presents them to the core over valid/ack, with redirect and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          TIMEOUT    = 16,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  input  logic             instr_ack,
  input  logic             pc_update,
  input  logic [31:0]      pc_new,
  output logic             halted,
  output logic             err_misalign,
  output logic             err_timeout,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Last tolerated wait value; a miss at this count means TIMEOUT idle cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [31:0]        instr_reg, instr_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               err_mis_reg, err_mis_next;
  logic               err_to_reg, err_to_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'd0;
      wait_reg    <= '0;
      count_reg   <= '0;
      err_mis_reg <= 1'b0;
      err_to_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      wait_reg    <= wait_next;
      count_reg   <= count_next;
      err_mis_reg <= err_mis_next;
      err_to_reg  <= err_to_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    wait_next    = wait_reg;
    count_next   = count_reg;
    err_mis_next = err_mis_reg;
    err_to_next  = err_to_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          wait_next  = '0;
          state_next = ST_ISSUE;
        end else if (wait_reg == WAIT_LAST) begin
          wait_next   = '0;
          err_to_next = 1'b1;
          state_next  = ST_HALT;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (instr_ack) begin
          if (count_reg != {CNT_W{1'b1}}) count_next = count_reg + 1'b1;
          // HALT word wins over any redirect presented with the same ack.
          if (instr_reg == HALT_INSTR) begin
            state_next = ST_HALT;
          end else if (pc_update && (pc_new[1:0] != 2'b00)) begin
            err_mis_next = 1'b1;
            state_next   = ST_HALT;
          end else begin
            pc_next    = pc_update ? pc_new : pc_reg + 32'd4;
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem_req     = (state_reg == ST_FETCH);
  assign imem_addr    = pc_reg;
  assign instr_valid  = (state_reg == ST_ISSUE);
  assign instr        = instr_reg;
  assign pc           = pc_reg;
  assign halted       = (state_reg == ST_HALT);
  assign err_misalign = err_mis_reg;
  assign err_timeout  = err_to_reg;
  assign fetch_count  = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: scenario tasks with inline checks;
// a second instance with RESET_PC=0xFFFF_FFFC covers PC wraparound.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, imem_ready, instr_ack, pc_update;
  logic [31:0] imem_rdata, pc_new;

  logic        imem_req, instr_valid, halted, err_misalign, err_timeout;
  logic [31:0] imem_addr, instr, pc;
  logic [15:0] fetch_count;

  logic        w_imem_req, w_instr_valid, w_halted, w_err_misalign, w_err_timeout;
  logic [31:0] w_imem_addr, w_instr, w_pc;
  logic [15:0] w_fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .instr_ack(instr_ack), .pc_update(pc_update), .pc_new(pc_new),
    .halted(halted), .err_misalign(err_misalign), .err_timeout(err_timeout),
    .fetch_count(fetch_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(w_instr_valid), .instr(w_instr), .pc(w_pc),
    .instr_ack(instr_ack), .pc_update(pc_update), .pc_new(pc_new),
    .halted(w_halted), .err_misalign(w_err_misalign), .err_timeout(w_err_timeout),
    .fetch_count(w_fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0;
    pc_update = 1'b0; imem_rdata = 32'd0; pc_new = 32'd0;
    tick();
    reset = 1'b0;
  endtask

  // Start from IDLE and bring one word into ISSUE (ready on the first FETCH cycle).
  task automatic start_and_fetch(input logic [31:0] word);
    start = 1'b1; tick(); start = 1'b0;
    imem_ready = 1'b1; imem_rdata = word; tick(); imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
    total++; if ({halted, err_misalign, err_timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {halted, err_misalign, err_timeout}); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (w_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc_w got=%h exp=fffffffc", w_pc); end
    // Idle without start: nothing happens even if memory claims ready.
    imem_ready = 1'b1; tick(); imem_ready = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b%b exp=00", imem_req, instr_valid); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin bad++; $display("FAIL seq_req[%0d] got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'(i * 4)); end
      imem_ready = 1'b1; imem_rdata = words[i]; tick(); imem_ready = 1'b0;
      total++; if (instr_valid !== 1'b1 || instr !== words[i] || pc !== 32'(i * 4)) begin bad++; $display("FAIL seq_issue[%0d] got valid=%b instr=%h pc=%h exp 1 %h %h", i, instr_valid, instr, pc, words[i], 32'(i * 4)); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_req_drop[%0d] got=%b exp=0", i, imem_req); end
      instr_ack = 1'b1; tick(); instr_ack = 1'b0;
      $display("seq fetch %0d word=%h", i, words[i]);
    end
    total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin bad++; $display("FAIL seq_next got req=%b addr=%h exp 1 0000000c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    start_and_fetch(32'hA0);
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'hA4; tick(); imem_ready = 1'b0;
    // pc_update without ack must be ignored.
    pc_update = 1'b1; pc_new = 32'h80; tick();
    total++; if (instr_valid !== 1'b1 || pc !== 32'd4) begin bad++; $display("FAIL noack_update got valid=%b pc=%h exp 1 00000004", instr_valid, pc); end
    pc_new = 32'h40; instr_ack = 1'b1; tick(); instr_ack = 1'b0; pc_update = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL redirect got req=%b addr=%h exp 1 00000040", imem_req, imem_addr); end
    total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL redirect_count got=%0d exp=2", fetch_count); end
    $display("redirect to %h", imem_addr);
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (imem_req !== 1'b1 || halted !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got req=%b halt=%b to=%b exp 1 0 0", imem_req, halted, err_timeout); end
    tick();
    total++; if (err_timeout !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL timeout got to=%b halt=%b req=%b exp 1 1 0", err_timeout, halted, imem_req); end
    total++; if (err_misalign !== 1'b0) begin bad++; $display("FAIL timeout_mis got=%b exp=0", err_misalign); end
    // Ready on the last allowed cycle still succeeds.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    imem_ready = 1'b1; imem_rdata = 32'h5A; tick(); imem_ready = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h5A || err_timeout !== 1'b0) begin bad++; $display("FAIL late_ready got valid=%b instr=%h to=%b exp 1 0000005a 0", instr_valid, instr, err_timeout); end
    // Wait counter restarts after a successful fetch.
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (imem_req !== 1'b1 || err_timeout !== 1'b0) begin bad++; $display("FAIL wait_restart got req=%b to=%b exp 1 0", imem_req, err_timeout); end
    $display("timeout scenario done");
  endtask

  task automatic test_misalign();
    do_reset();
    start_and_fetch(32'h55);
    instr_ack = 1'b1; pc_update = 1'b1; pc_new = 32'h42; tick();
    instr_ack = 1'b0; pc_update = 1'b0;
    total++; if (err_misalign !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL misalign got mis=%b halt=%b exp 1 1", err_misalign, halted); end
    total++; if (pc !== 32'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL misalign_pc got pc=%h req=%b valid=%b exp 0 0 0", pc, imem_req, instr_valid); end
    total++; if (fetch_count !== 16'd1) begin bad++; $display("FAIL misalign_count got=%0d exp=1", fetch_count); end
    $display("misalign halt pc=%h", pc);
  endtask

  task automatic test_halt();
    do_reset();
    start_and_fetch(32'hFFFF_FFFF);
    instr_ack = 1'b1; pc_update = 1'b1; pc_new = 32'h80; tick();
    instr_ack = 1'b0; pc_update = 1'b0;
    total++; if (halted !== 1'b1 || pc !== 32'd0) begin bad++; $display("FAIL halt got halt=%b pc=%h exp 1 00000000", halted, pc); end
    total++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL halt_errs got %b%b exp 00", err_misalign, err_timeout); end
    start = 1'b1; imem_ready = 1'b1; instr_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0;
    total++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 16'd1) begin bad++; $display("FAIL halt_sticky got halt=%b req=%b valid=%b cnt=%0d exp 1 0 0 1", halted, imem_req, instr_valid, fetch_count); end
    $display("halt sticky checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (imem_req !== 1'b0 || pc !== 32'd0) begin bad++; $display("FAIL rst_fetch got req=%b pc=%h exp 0 0", imem_req, pc); end
    start_and_fetch(32'h77);
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h78; tick(); imem_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (instr_valid !== 1'b0 || pc !== 32'd0 || fetch_count !== 16'd0 || instr !== 32'd0) begin bad++; $display("FAIL rst_issue got valid=%b pc=%h cnt=%0d instr=%h exp 0 0 0 0", instr_valid, pc, fetch_count, instr); end
    // Wrapping instance: fetch at 0xFFFFFFFC then next fetch at 0.
    start_and_fetch(32'h99);
    total++; if (w_instr_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_issue got valid=%b pc=%h exp 1 fffffffc", w_instr_valid, w_pc); end
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
    total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got req=%b addr=%h exp 1 00000000", w_imem_req, w_imem_addr); end
    $display("reset mid-transaction and wrap done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_timeout();
    test_misalign();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
